// File: rtl/readout_sched_pkg.sv
// Shared constants for the timestamper readout scheduler: FSM encoding,
// HOLD length and header byte layout.
package readout_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HDR    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_UNLOAD = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // Cycles spent in HOLD so a channel's delayed attention catches up with
  // the pop or overrun clear that just happened.
  localparam int HOLD_CYCLES = 3;

  // Header byte: {ovr, 4'b0000, channel}
  localparam int HDR_OVR_BIT = 7;
  localparam int HDR_CH_W    = 3;

  function automatic logic [7:0] hdr_byte(input logic ovr, input logic [HDR_CH_W-1:0] ch);
    logic [7:0] b;
    b = '0;
    b[HDR_OVR_BIT]  = ovr;
    b[HDR_CH_W-1:0] = ch;
    return b;
  endfunction

endpackage

// File: rtl/readout_sched_rr_pick.sv
// Round-robin picker: returns the first attentive channel found searching
// upward from (last + 1) mod NCH, wrapping around.
module rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_att,
  input  logic [2:0]     i_last,
  output logic [2:0]     o_grant,
  output logic           o_valid
);

  int w_dist;
  int w_best;

  // Pick the attentive channel with the smallest rotational distance from last+1
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_best  = NCH;
    w_dist  = 0;
    for (int c = 0; c < NCH; c++) begin
      w_dist = (c + 2 * NCH - int'(i_last) - 1) % NCH;
      if (i_att[c] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_grant = 3'(c);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/readout_sched.sv
// Readout scheduler: grants one timestamper channel at a time, streams a
// header and (unless overrun) its 8-byte event, then pops or clears the
// channel and waits for its attention flag to settle.
module readout_sched
  import readout_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [NCH-1:0]   attention,
  input  logic [NCH-1:0]   overrun,
  input  logic [8*NCH-1:0] chdata,
  output logic [2:0]       byteaddr,
  output logic [NCH-1:0]   unload,
  output logic [NCH-1:0]   clearoverrun,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy
);

  logic [2:0]     r_state;
  logic [2:0]     r_grant;
  logic [2:0]     r_last;
  logic [2:0]     r_idx;
  logic           r_ovr;
  logic [1:0]     r_hold;
  logic [NCH-1:0] r_clr;

  logic [2:0]     w_pick_grant;
  logic           w_pick_vld;
  logic           w_pick_ovr;
  logic           w_xfer;
  logic [NCH-1:0] w_grant_oh;
  logic [7:0]     w_chbyte;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .i_att   (attention),
    .i_last  (r_last),
    .o_grant (w_pick_grant),
    .o_valid (w_pick_vld)
  );

  // Overrun flag of the channel the picker is offering, captured at grant
  always_comb begin
    w_pick_ovr = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_pick_grant == 3'(i)) w_pick_ovr = overrun[i];
    end
  end

  // One-hot decode of the granted channel and its byte lane
  always_comb begin
    w_grant_oh = '0;
    w_chbyte   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_grant == 3'(i)) begin
        w_grant_oh[i] = 1'b1;
        w_chbyte      = chdata[8*i +: 8];
      end
    end
  end

  assign w_xfer = tx_valid & tx_ready;

  // Packet sequencer; reset aborts any packet without pop or clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= 3'(NCH - 1);
      r_idx   <= '0;
      r_ovr   <= 1'b0;
      r_hold  <= '0;
      r_clr   <= '0;
    end else begin
      r_clr <= '0;
      case (r_state)
        ST_IDLE: begin
          if (enable && w_pick_vld) begin
            r_grant <= w_pick_grant;
            r_last  <= w_pick_grant;
            r_ovr   <= w_pick_ovr;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (w_xfer) begin
            if (r_ovr) begin
              r_clr   <= w_grant_oh;
              r_hold  <= 2'(HOLD_CYCLES - 1);
              r_state <= ST_HOLD;
            end else begin
              r_idx   <= '0;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_xfer) begin
            if (r_idx == 3'd7) begin
              r_idx   <= '0;
              r_state <= ST_UNLOAD;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        ST_UNLOAD: begin
          r_hold  <= 2'(HOLD_CYCLES - 1);
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold == 2'd0) r_state <= ST_IDLE;
          else                r_hold  <= r_hold - 2'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state, grant and byte index
  always_comb begin
    tx_valid     = (r_state == ST_HDR) || (r_state == ST_DATA);
    busy         = (r_state != ST_IDLE);
    byteaddr     = (r_state == ST_DATA) ? r_idx : 3'd0;
    unload       = (r_state == ST_UNLOAD) ? w_grant_oh : '0;
    clearoverrun = r_clr;
    case (r_state)
      ST_HDR:  tx_data = hdr_byte(r_ovr, r_grant);
      ST_DATA: tx_data = w_chbyte;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_readout_sched.sv
// Bench for readout_sched: channel FIFO models feed the DUT, a packet-level
// reference model queues the expected byte stream and pop/clear events, and
// a monitor compares whatever the DUT emits against those queues.
module tb_readout_sched;

  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             enable = 1'b0;
  logic             tx_ready = 1'b0;
  logic [NCH-1:0]   attention = '0;
  logic [NCH-1:0]   overrun;
  logic [8*NCH-1:0] chdata;
  logic [2:0]       byteaddr;
  logic [NCH-1:0]   unload;
  logic [NCH-1:0]   clearoverrun;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             busy;

  always #5 clk = ~clk;

  readout_sched #(.NCH(NCH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .attention    (attention),
    .overrun      (overrun),
    .chdata       (chdata),
    .byteaddr     (byteaddr),
    .unload       (unload),
    .clearoverrun (clearoverrun),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy)
  );

  // ---------------- channel models ----------------
  logic [63:0] stg_word [NCH][4];
  int          stg_n    [NCH];
  bit          stg_ovr  [NCH];
  int          ch_cnt   [NCH];
  int          ch_rd    [NCH];
  bit          ch_ovr   [NCH];
  int          load_seq  = 0;
  int          load_done = 0;

  function automatic logic [7:0] byte_of(input logic [63:0] w, input int k);
    return w[8*k +: 8];
  endfunction

  always @(posedge clk) begin
    if (load_seq != load_done) begin
      load_done <= load_seq;
      for (int i = 0; i < NCH; i++) begin
        ch_cnt[i] <= stg_n[i];
        ch_rd[i]  <= 0;
        ch_ovr[i] <= stg_ovr[i];
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (unload[i])       ch_rd[i]  <= ch_rd[i] + 1;
        if (clearoverrun[i]) ch_ovr[i] <= 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++)
      attention[i] <= (ch_rd[i] < ch_cnt[i]) || ch_ovr[i];
  end

  always_comb begin
    chdata  = '0;
    overrun = '0;
    for (int i = 0; i < NCH; i++) begin
      overrun[i] = ch_ovr[i];
      if (ch_rd[i] < ch_cnt[i])
        chdata[8*i +: 8] = byte_of(stg_word[i][ch_rd[i] & 3], int'(byteaddr));
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] exp_b [$];
  int         exp_e [$];   // channel, +16 for an overrun clear
  int         m_cnt [NCH];
  int         m_rd  [NCH];
  bit         m_ovr [NCH];
  int         mdl_last = NCH - 1;

  // Serve every attentive channel in round-robin order until none is left.
  task automatic model_run();
    int  c;
    bit  found;
    for (int guard = 0; guard < 64; guard++) begin
      found = 0;
      c     = 0;
      for (int k = 1; k <= NCH; k++) begin
        int cc;
        cc = (mdl_last + k) % NCH;
        if (!found && (m_ovr[cc] || (m_rd[cc] < m_cnt[cc]))) begin
          found = 1;
          c     = cc;
        end
      end
      if (!found) break;
      if (m_ovr[c]) begin
        exp_b.push_back(8'h80 | 8'(c));
        exp_e.push_back(16 + c);
        m_ovr[c] = 0;
      end else begin
        exp_b.push_back(8'(c));
        for (int b = 0; b < 8; b++) exp_b.push_back(byte_of(stg_word[c][m_rd[c]], b));
        exp_e.push_back(c);
        m_rd[c]++;
      end
      mdl_last = c;
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         n_checks = 0;
  int         n_err    = 0;
  int         xfer_total = 0;
  int         tmo_req = 0, tmo_seen = 0;
  int         fin_req = 0, fin_seen = 0;
  int         qchk_req = 0, qchk_seen = 0, qchk_want = 0;
  bit         p_stall = 0, p_xfer = 0, p_busy = 0, p_en = 0;
  logic [7:0] p_data = '0;
  int         ev_dist = 0;
  int         ev_want = -1;

  function automatic int oh_idx(input logic [NCH-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NCH; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    bit         xfer;
    logic [7:0] eb;
    int         got, want;
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got pending bytes/events after budget, want all drained");
    end
    if (qchk_req != qchk_seen) begin
      qchk_seen = qchk_req;
      n_checks++;
      if (exp_b.size() != qchk_want) begin
        n_err++;
        $display("FAIL enable_block: got %0d bytes still pending, want %0d", exp_b.size(), qchk_want);
      end
    end
    if (!rstn) begin
      n_checks++;
      if ({tx_valid, busy, unload, clearoverrun, byteaddr, tx_data} != '0) begin
        n_err++;
        $display("FAIL reset_vals: got valid=%b busy=%b unl=%b clr=%b ba=%0d data=%02h, want all zero",
                 tx_valid, busy, unload, clearoverrun, byteaddr, tx_data);
      end
      p_stall = 0; p_xfer = 0; p_busy = 0; p_en = 0; ev_want = -1;
    end else begin
      xfer = tx_valid && tx_ready;
      if (p_stall) begin
        n_checks++;
        if (!tx_valid || tx_data != p_data) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%b data=%02h, want valid=1 data=%02h", tx_valid, tx_data, p_data);
        end
      end
      if (xfer) begin
        xfer_total++;
        n_checks++;
        if (exp_b.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %02h, want no transfer", tx_data);
        end else begin
          eb = exp_b.pop_front();
          if (tx_data != eb) begin
            n_err++;
            $display("FAIL byte: got %02h, want %02h", tx_data, eb);
          end
        end
      end
      if (unload != '0 || clearoverrun != '0) begin
        n_checks++;
        if ($countones(unload | clearoverrun) != 1 || (unload != '0 && clearoverrun != '0)) begin
          n_err++;
          $display("FAIL pulse_excl: got unl=%b clr=%b, want a single one-hot pulse", unload, clearoverrun);
        end
        got = (unload != '0) ? oh_idx(unload) : 16 + oh_idx(clearoverrun);
        n_checks++;
        if (exp_e.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: got event %0d, want none", got);
        end else begin
          want = exp_e.pop_front();
          if (got != want) begin
            n_err++;
            $display("FAIL pulse_event: got event %0d, want %0d", got, want);
          end
        end
        n_checks++;
        if (!p_xfer) begin
          n_err++;
          $display("FAIL pulse_timing: got pulse without a transfer the cycle before, want pulse right after last byte");
        end
        ev_dist = 0;
        ev_want = (unload != '0) ? 4 : 3;
      end else if (ev_want >= 0) begin
        ev_dist++;
        if (!busy) begin
          n_checks++;
          if (ev_dist != ev_want) begin
            n_err++;
            $display("FAIL hold_len: got busy low %0d cycles after pulse, want %0d", ev_dist, ev_want);
          end
          ev_want = -1;
        end
      end
      if (busy && !p_busy) begin
        n_checks++;
        if (!p_en) begin
          n_err++;
          $display("FAIL grant_disabled: got grant with enable=%b, want enable=1", p_en);
        end
      end
      if (busy && !tx_valid) begin
        n_checks++;
        if (byteaddr != 3'd0) begin
          n_err++;
          $display("FAIL byteaddr_idle: got %0d, want 0", byteaddr);
        end
      end
      p_stall = tx_valid && !tx_ready;
      p_data  = tx_data;
      p_xfer  = xfer;
      p_busy  = busy;
      p_en    = enable;
    end
    if (fin_req != fin_seen) begin
      fin_seen = fin_req;
      n_checks++;
      if (exp_b.size() != 0 || exp_e.size() != 0) begin
        n_err++;
        $display("FAIL leftover: got %0d bytes %0d events unsent, want 0 0", exp_b.size(), exp_e.size());
      end
    end
  end

  // ---------------- stimulus ----------------
  int rdy_mode = 0;  // 0 always ready, 1 ~50%, 2 ~25%
  int en_mode  = 0;  // 0 always on, 1 random dropouts, 2 forced off

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ($urandom_range(0, 1) == 1);
      default: tx_ready = ($urandom_range(0, 3) == 0);
    endcase
    case (en_mode)
      0:       enable = 1'b1;
      1:       enable = ($urandom_range(0, 3) != 0);
      default: enable = 1'b0;
    endcase
  endtask

  task automatic clear_stage();
    for (int i = 0; i < NCH; i++) begin
      stg_n[i]   = 0;
      stg_ovr[i] = 0;
      for (int k = 0; k < 4; k++) stg_word[i][k] = {$urandom, $urandom};
    end
  endtask

  task automatic launch();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = stg_n[i];
      m_rd[i]  = 0;
      m_ovr[i] = stg_ovr[i];
    end
    model_run();
    load_seq++;
    tick();
  endtask

  task automatic drain(input int budget);
    int idle;
    idle = 0;
    for (int t = 0; t < budget; t++) begin
      tick();
      if (exp_b.size() == 0 && exp_e.size() == 0 && !busy) idle++;
      else idle = 0;
      if (idle >= 5) return;
    end
    tmo_req++;
    exp_b.delete();
    exp_e.delete();
    tick();
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int base;
    base = xfer_total;
    for (int t = 0; t < budget; t++) begin
      if (xfer_total - base >= n) return;
      tick();
    end
    tmo_req++;
  endtask

  initial begin
    clear_stage();
    for (int i = 0; i < 4; i++) tick();
    rstn = 1'b1;
    tick();

    // all four channels attentive from reset: order 0,1,2,3,0,1,2,3
    clear_stage();
    for (int i = 0; i < NCH; i++) stg_n[i] = 2;
    launch();
    drain(2000);

    // single channel 2 packet, known bytes
    clear_stage();
    stg_n[2] = 1;
    stg_word[2][0] = 64'h8877665544332211;
    launch();
    drain(1000);

    // channel 1 overrun plus one pending event
    clear_stage();
    stg_ovr[1] = 1;
    stg_n[1]   = 1;
    launch();
    drain(1000);

    // randomized batches with backpressure and enable dropouts
    for (int b = 0; b < 25; b++) begin
      clear_stage();
      for (int i = 0; i < NCH; i++) begin
        stg_n[i]   = $urandom_range(0, 2);
        stg_ovr[i] = ($urandom_range(0, 3) == 0);
      end
      rdy_mode = $urandom_range(0, 2);
      en_mode  = $urandom_range(0, 1);
      launch();
      drain(4000);
      en_mode  = 0;
      rdy_mode = 0;
    end

    // enable falls mid-packet: first packet completes, second stays pending
    clear_stage();
    stg_n[1] = 1;
    stg_n[3] = 1;
    launch();
    wait_xfers(5, 200);
    en_mode = 2;
    for (int t = 0; t < 40; t++) tick();
    qchk_want = 9;
    qchk_req++;
    tick();
    en_mode = 0;
    drain(1000);

    // reset during byte 5 of a packet, then re-serve from the header
    clear_stage();
    stg_n[0] = 2;
    stg_n[2] = 1;
    launch();
    wait_xfers(6, 200);
    #2;
    rstn = 1'b0;
    exp_b.delete();
    exp_e.delete();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i] = ch_cnt[i];
      m_rd[i]  = ch_rd[i];
      m_ovr[i] = ch_ovr[i];
    end
    mdl_last = NCH - 1;
    model_run();
    tick();
    tick();
    rstn = 1'b1;
    drain(2000);

    fin_req++;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
